// File: rtl/vx_mem_responder.sv
// Memory-side responder: byte-writable line RAM, fixed-latency read pipeline and an
// in-order first-word-fall-through response queue that absorbs mem_rsp backpressure.

module vx_mem_responder #(
   parameter int DATA_WIDTH     = 512,
   parameter int ADDR_WIDTH     = 26,
   parameter int TAG_WIDTH      = 8,
   parameter int RAM_ADDR_WIDTH = 10,
   parameter int LATENCY        = 4,
   parameter int QUEUE_SIZE     = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    mem_req_valid,
   input  logic                    mem_req_rw,
   input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
   input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
   input  logic [DATA_WIDTH-1:0]   mem_req_data,
   input  logic [TAG_WIDTH-1:0]    mem_req_tag,
   output logic                    mem_req_ready,
   output logic                    mem_rsp_valid,
   output logic [DATA_WIDTH-1:0]   mem_rsp_data,
   output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
   input  logic                    mem_rsp_ready,
   output logic                    busy
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int CW    = $clog2(QUEUE_SIZE + 1);
   localparam int PW    = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;
   localparam logic [CW-1:0] Q_MAX    = CW'(QUEUE_SIZE);
   localparam logic [PW-1:0] PTR_LAST = PW'(QUEUE_SIZE - 1);

   logic [DATA_WIDTH-1:0]     ram_r [0:(1 << RAM_ADDR_WIDTH)-1];
   logic [RAM_ADDR_WIDTH-1:0] ram_addr_s;
   logic                      unused_addr_s;

   logic req_fire_s, rd_fire_s, wr_fire_s, rsp_fire_s, push_s, pop_s;

   logic [LATENCY-1:0]    pipe_valid_r;
   logic [DATA_WIDTH-1:0] pipe_data_r [LATENCY];
   logic [TAG_WIDTH-1:0]  pipe_tag_r  [LATENCY];

   logic [DATA_WIDTH-1:0] fifo_data_r [QUEUE_SIZE];
   logic [TAG_WIDTH-1:0]  fifo_tag_r  [QUEUE_SIZE];
   logic [PW-1:0]         wr_ptr_r, rd_ptr_r;
   logic [CW-1:0]         fifo_cnt_r, fifo_cnt_next_s;
   logic [CW-1:0]         outstanding_r, outstanding_next_s;
   logic                  rsp_valid_r, busy_r;

   // Only the low address bits select a line; the rest alias.
   assign ram_addr_s    = mem_req_addr[RAM_ADDR_WIDTH-1:0];
   assign unused_addr_s = ^mem_req_addr;

   // Ready depends only on registered occupancy, never on mem_rsp_ready.
   assign mem_req_ready = ~reset & (outstanding_r < Q_MAX);
   assign req_fire_s    = mem_req_valid & mem_req_ready;
   assign rd_fire_s     = req_fire_s & ~mem_req_rw;
   assign wr_fire_s     = req_fire_s & mem_req_rw;
   assign rsp_fire_s    = rsp_valid_r & mem_rsp_ready;
   assign push_s        = pipe_valid_r[LATENCY-1];
   assign pop_s         = rsp_fire_s;

   assign mem_rsp_valid = rsp_valid_r;
   assign mem_rsp_data  = fifo_data_r[rd_ptr_r];
   assign mem_rsp_tag   = fifo_tag_r[rd_ptr_r];
   assign busy          = busy_r;

   // Byte-masked line write; RAM contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_fire_s) begin
         for (int i = 0; i < BYTES; i++) begin
            if (mem_req_byteen[i]) begin
               ram_r[ram_addr_s][8*i +: 8] <= mem_req_data[8*i +: 8];
            end
         end
      end
   end

   // Read-pipeline valid bits; a reset drops every in-flight read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pipe_valid_r <= '0;
      end else begin
         pipe_valid_r[0] <= rd_fire_s;
         for (int k = 1; k < LATENCY; k++) begin
            pipe_valid_r[k] <= pipe_valid_r[k-1];
         end
      end
   end

   // Read-pipeline payload: stage 0 samples the RAM line in the fire cycle.
   always_ff @(posedge clk) begin
      pipe_data_r[0] <= ram_r[ram_addr_s];
      pipe_tag_r[0]  <= mem_req_tag;
      for (int k = 1; k < LATENCY; k++) begin
         pipe_data_r[k] <= pipe_data_r[k-1];
         pipe_tag_r[k]  <= pipe_tag_r[k-1];
      end
   end

   // Next occupancy of the response queue and of the outstanding-read counter.
   always_comb begin
      fifo_cnt_next_s    = fifo_cnt_r;
      outstanding_next_s = outstanding_r;
      case ({push_s, pop_s})
         2'b10:   fifo_cnt_next_s = fifo_cnt_r + {{(CW-1){1'b0}}, 1'b1};
         2'b01:   fifo_cnt_next_s = fifo_cnt_r - {{(CW-1){1'b0}}, 1'b1};
         default: fifo_cnt_next_s = fifo_cnt_r;
      endcase
      case ({rd_fire_s, rsp_fire_s})
         2'b10:   outstanding_next_s = outstanding_r + {{(CW-1){1'b0}}, 1'b1};
         2'b01:   outstanding_next_s = outstanding_r - {{(CW-1){1'b0}}, 1'b1};
         default: outstanding_next_s = outstanding_r;
      endcase
   end

   // Queue pointers, counters and the registered status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r      <= '0;
         rd_ptr_r      <= '0;
         fifo_cnt_r    <= '0;
         outstanding_r <= '0;
         rsp_valid_r   <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? '0 : wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? '0 : rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         end
         fifo_cnt_r    <= fifo_cnt_next_s;
         outstanding_r <= outstanding_next_s;
         rsp_valid_r   <= (fifo_cnt_next_s != '0);
         busy_r        <= (outstanding_next_s != '0);
      end
   end

   // Queue storage; the head entry holds steady until it is popped.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_data_r[wr_ptr_r] <= pipe_data_r[LATENCY-1];
         fifo_tag_r[wr_ptr_r]  <= pipe_tag_r[LATENCY-1];
      end
   end

   // Configuration sanity and queue overflow/underflow guards.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (LATENCY >= 1 && QUEUE_SIZE >= 1 && (DATA_WIDTH % 8) == 0);
         assert (!(push_s && fifo_cnt_r == Q_MAX));
         assert (!(pop_s && fifo_cnt_r == '0));
      end
   end

endmodule

// File: tb/tb_vx_mem_responder.sv
// Self-checking bench for vx_mem_responder: directed table, hand-written corner
// sequences and randomized traffic against a queue/array reference model.

module tb_vx_mem_responder;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         mem_req_valid = 1'b0;
   logic         mem_req_rw = 1'b0;
   logic [63:0]  mem_req_byteen = '0;
   logic [25:0]  mem_req_addr = '0;
   logic [511:0] mem_req_data = '0;
   logic [7:0]   mem_req_tag = '0;
   logic         mem_req_ready;
   logic         mem_rsp_valid;
   logic [511:0] mem_rsp_data;
   logic [7:0]   mem_rsp_tag;
   logic         mem_rsp_ready = 1'b0;
   logic         busy;

   vx_mem_responder dut (
      .clk(clk), .reset(reset),
      .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
      .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr),
      .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
      .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
      .mem_rsp_ready(mem_rsp_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   localparam int LAT = 4;
   localparam int QSZ = 8;

   typedef struct {
      logic [511:0] data;
      logic [7:0]   tag;
      int           avail;
      bit           known;
   } rsp_t;

   typedef struct {
      logic         rw;
      logic [25:0]  addr;
      logic [63:0]  byteen;
      logic [511:0] data;
      logic [7:0]   tag;
      logic [511:0] exp_data;
   } vec_t;

   rsp_t         q[$];
   logic [511:0] ram_m [int];
   int           edge_n = 0;
   int           checks = 0;
   int           errors = 0;
   bit           last_req_fire, last_rsp_fire;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit exp_valid();
      return (q.size() > 0) && (q[0].avail <= edge_n);
   endfunction

   task automatic check_outputs();
      chk("req_ready", mem_req_ready, !reset && q.size() < QSZ);
      chk("rsp_valid", mem_rsp_valid, exp_valid());
      chk("busy", busy, q.size() != 0);
      if (exp_valid()) begin
         chk("rsp_tag", mem_rsp_tag, q[0].tag);
         if (q[0].known) chk("rsp_data", mem_rsp_data, q[0].data);
      end
   endtask

   // One clock: decide handshakes from the model, advance model, then compare.
   task automatic cycle();
      bit rf, pf;
      int a;
      rf = !reset && mem_req_valid && (q.size() < QSZ);
      pf = !reset && mem_rsp_ready && exp_valid();
      a  = int'(mem_req_addr[9:0]);
      @(posedge clk);
      edge_n++;
      if (pf) void'(q.pop_front());
      if (rf) begin
         if (mem_req_rw) begin
            if (!ram_m.exists(a)) ram_m[a] = '0;
            for (int i = 0; i < 64; i++)
               if (mem_req_byteen[i]) ram_m[a][8*i +: 8] = mem_req_data[8*i +: 8];
         end else begin
            q.push_back('{data: ram_m.exists(a) ? ram_m[a] : '0, tag: mem_req_tag,
                          avail: edge_n + LAT, known: ram_m.exists(a)});
         end
      end
      if (reset) q.delete();
      last_req_fire = rf;
      last_rsp_fire = pf;
      #1;
      check_outputs();
   endtask

   task automatic do_req(input logic rw, input logic [25:0] addr, input logic [63:0] be,
                         input logic [511:0] d, input logic [7:0] tag);
      int n;
      n = 0;
      mem_req_valid = 1'b1; mem_req_rw = rw; mem_req_addr = addr;
      mem_req_byteen = be; mem_req_data = d; mem_req_tag = tag;
      do begin
         cycle();
         n++;
      end while (!last_req_fire && n < 50);
      chk("req_accept_timeout", last_req_fire, 1'b1);
      mem_req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      mem_rsp_ready = 1'b1;
      while (q.size() != 0 && n < 100) begin
         cycle();
         n++;
      end
      chk("drain_empty", busy, 1'b0);
   endtask

   logic [511:0] old_d, new_d, got[$], rnd;
   vec_t         tbl[7];
   int           lat, n, exp_tag;

   initial begin
      old_d = {64{8'h3C}};
      new_d = {64{8'hC3}};
      tbl[0] = '{1'b1, 26'h5,       {64{1'b1}}, {64{8'hA5}}, 8'h0, '0};
      tbl[1] = '{1'b0, 26'h5,       '0,         '0,          8'h3, {64{8'hA5}}};
      tbl[2] = '{1'b1, 26'h5,       {64{1'b1}}, '0,          8'h0, '0};
      tbl[3] = '{1'b1, 26'h5,       64'h1,      {{63{8'hFF}}, 8'h7E}, 8'h0, '0};
      tbl[4] = '{1'b0, 26'h5,       '0,         '0,          8'h4, {{63{8'h00}}, 8'h7E}};
      tbl[5] = '{1'b1, 26'h3FF_C007, {64{1'b1}}, {32{16'h1234}}, 8'h0, '0};
      tbl[6] = '{1'b0, 26'h7,       '0,         '0,          8'hFF, {32{16'h1234}}};

      // Power-on reset.
      reset = 1'b1;
      #1;
      check_outputs();
      cycle();
      cycle();
      reset = 1'b0;
      #1;
      chk("ready_after_reset", mem_req_ready, 1'b1);

      // Directed table, one request at a time.
      mem_rsp_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         do_req(tbl[i].rw, tbl[i].addr, tbl[i].byteen, tbl[i].data, tbl[i].tag);
         if (!tbl[i].rw) begin
            lat = 0;
            while (!mem_rsp_valid && lat < 20) begin
               cycle();
               lat++;
            end
            chk("tbl_latency", lat, LAT);
            chk("tbl_data", mem_rsp_data, tbl[i].exp_data);
            chk("tbl_tag", mem_rsp_tag, tbl[i].tag);
            cycle();
         end
      end

      // Fill to QUEUE_SIZE with responses held back.
      mem_rsp_ready = 1'b0;
      for (int t = 0; t < 8; t++) do_req(1'b0, 26'h5, '0, '0, 8'(t));
      chk("full_ready_low", mem_req_ready, 1'b0);
      chk("full_busy", busy, 1'b1);
      for (int i = 0; i < 6; i++) cycle();

      // Request and response together at the full boundary.
      mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = 26'h5; mem_req_tag = 8'd8;
      mem_rsp_ready = 1'b1;
      chk("bound_ready_before", mem_req_ready, 1'b0);
      cycle();
      chk("bound_pop_head", mem_rsp_tag, 8'd1);
      chk("bound_ready_after", mem_req_ready, 1'b1);
      mem_rsp_ready = 1'b0;
      cycle();
      mem_req_valid = 1'b0;
      chk("bound_refull", mem_req_ready, 1'b0);
      mem_rsp_ready = 1'b1;
      exp_tag = 1;
      n = 0;
      while (mem_rsp_valid && n < 20) begin
         chk("order_tag", mem_rsp_tag, 8'(exp_tag));
         exp_tag++;
         cycle();
         n++;
      end
      chk("order_count", n, 8);
      chk("order_busy_done", busy, 1'b0);

      // Reset while reads are in flight.
      mem_rsp_ready = 1'b0;
      for (int t = 20; t < 23; t++) do_req(1'b0, 26'h5, '0, '0, 8'(t));
      cycle();
      reset = 1'b1;
      q.delete();
      #1;
      chk("rst_ready", mem_req_ready, 1'b0);
      chk("rst_valid", mem_rsp_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      cycle();
      reset = 1'b0;
      #1;
      chk("rst_ready_after", mem_req_ready, 1'b1);
      mem_rsp_ready = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (mem_rsp_valid) n++;
      end
      chk("rst_no_rsp", n, 0);
      do_req(1'b0, 26'h5, '0, '0, 8'h55);
      for (int i = 0; i < LAT; i++) cycle();
      chk("rst_ram_kept", mem_rsp_data, {{63{8'h00}}, 8'h7E});
      drain();

      // Read / write / read to the same line back-to-back.
      do_req(1'b1, 26'h9, {64{1'b1}}, old_d, 8'h0);
      do_req(1'b0, 26'h9, '0, '0, 8'd30);
      do_req(1'b1, 26'h9, {64{1'b1}}, new_d, 8'h0);
      do_req(1'b0, 26'h9, '0, '0, 8'd31);
      n = 0;
      while (got.size() < 2 && n < 20) begin
         if (mem_rsp_valid) got.push_back(mem_rsp_data);
         cycle();
         n++;
      end
      chk("raw_count", got.size(), 2);
      if (got.size() == 2) begin
         chk("raw_old", got[0], old_d);
         chk("raw_new", got[1], new_d);
      end

      // Randomized traffic over 16 pre-initialized lines.
      for (int a = 0; a < 16; a++) begin
         for (int w = 0; w < 16; w++) rnd[32*w +: 32] = $urandom();
         do_req(1'b1, 26'(a), {64{1'b1}}, rnd, 8'h0);
      end
      for (int c = 0; c < 400; c++) begin
         for (int w = 0; w < 16; w++) rnd[32*w +: 32] = $urandom();
         mem_req_valid  = ($urandom_range(0, 3) != 0);
         mem_req_rw     = ($urandom_range(0, 2) == 0);
         mem_req_addr   = {16'($urandom()), 6'd0, 4'($urandom())};
         mem_req_byteen = {$urandom(), $urandom()};
         mem_req_data   = rnd;
         mem_req_tag    = 8'($urandom());
         mem_rsp_ready  = ($urandom_range(0, 3) != 0);
         cycle();
      end
      mem_req_valid = 1'b0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
